// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and constants for the ID/EX operand select
//                stage: select-width helper and default source encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    // Default operand source encodings for a 3-source lane.
    localparam int SRC_RF    = 0;   // register file read data
    localparam int SRC_EXMEM = 1;   // forward from EX/MEM
    localparam int SRC_MEMWB = 2;   // forward from MEM/WB

    // Width of a select field for n sources; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n
//  Description : Purely combinational N:1 selector. Out-of-range select
//                codes route the last source and raise out_of_range.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_n
    import core_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    localparam int SELW  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]         sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_of_range
);

    logic [WIDTH-1:0] w_sel_data;

    // Default to the last source so any code >= NUM_IN (legacy code 3 on a
    // 3-input mux) returns it; in-range codes override below.
    always_comb begin
        w_sel_data = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
        for (int i = 0; i < NUM_IN - 1; i++) begin
            if (sel == SELW'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign out_data = w_sel_data;

    // Zero-extended compare; folds to constant 0 when NUM_IN is a power of two.
    assign out_of_range = (32'(sel) >= 32'(NUM_IN));

endmodule : mux_n
`default_nettype wire

// File: rtl/operand_select_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_select_stage
//  Description : Registered NUM_LANES x (NUM_IN:1) operand selector at the
//                ID/EX boundary with stall, flush and a sticky out-of-range
//                select flag. All outputs come straight from flops.
//  Revision    : 1.0  initial release
// ============================================================================
module operand_select_stage
    import core_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 3,
    parameter int NUM_LANES = 2,
    localparam int SELW     = sel_width(NUM_IN)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_LANES*NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_LANES*SELW-1:0]         sel,
    input  logic                              in_valid,
    input  logic                              stall,
    input  logic                              flush,
    output logic [NUM_LANES*WIDTH-1:0]        out_data,
    output logic                              out_valid,
    output logic                              sel_err
);

    logic [NUM_LANES*WIDTH-1:0] w_lane_data;
    logic [NUM_LANES-1:0]       w_lane_oor;
    logic                       w_any_oor;

    logic [NUM_LANES*WIDTH-1:0] r_out_data;
    logic                       r_out_valid;
    logic                       r_sel_err;

    // One independent selector per operand lane (lane 0 = rs, lane 1 = rt).
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mux_n #(
            .WIDTH  (WIDTH),
            .NUM_IN (NUM_IN)
        ) u_mux (
            .in_data      (in_data[l*NUM_IN*WIDTH +: NUM_IN*WIDTH]),
            .sel          (sel[l*SELW +: SELW]),
            .out_data     (w_lane_data[l*WIDTH +: WIDTH]),
            .out_of_range (w_lane_oor[l])
        );
    end

    assign w_any_oor = |w_lane_oor;

    // Pipeline register: reset > flush > stall > load. Flush leaves the
    // sticky error untouched; only a real instruction can set it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (flush) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (!stall) begin
            r_out_data  <= w_lane_data;
            r_out_valid <= in_valid;
            if (in_valid && w_any_oor) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;

endmodule : operand_select_stage
`default_nettype wire

// File: doc/operand_select_stage.md
# operand_select_stage

Registered, parametrised N:1 operand selector for the ID/EX boundary of the pipelined MIPS core. It replaces the fixed 2-input and 3-input 32-bit selectors with NUM_LANES independent lanes, one per operand (rs and rt by default). Each lane picks one of NUM_IN sources: register file, EX/MEM forward, MEM/WB forward, and further sources for extended configurations. Results are captured in a pipeline register that supports stall, flush and out-of-range select detection.

## Interface
- WIDTH, 32, data width per source and per lane output
- NUM_IN, 3, sources per lane (≥2); SELW = max(1, clog2(NUM_IN))
- NUM_LANES, 2, independent operand lanes (≥1)
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_data  input  NUM_LANES*NUM_IN*WIDTH  lane l, source i at bits [(l*NUM_IN+i)*WIDTH +: WIDTH]
- sel  input  NUM_LANES*SELW  lane l select at [l*SELW +: SELW]
- in_valid  input  1  upstream stage holds a real instruction
- stall  input  1  hazard unit holds this stage
- flush  input  1  branch/jump squash; inserts a bubble
- out_data  output  NUM_LANES*WIDTH  registered selected operands, lane l at [l*WIDTH +: WIDTH]
- out_valid  output  1  out_data belongs to a real instruction
- sel_err  output  1  sticky: an out-of-range select was loaded since reset

## Operation
- Per lane, combinational select: sel = i < NUM_IN → source i. sel ≥ NUM_IN → source NUM_IN-1, which preserves the legacy 3-input behaviour where code 3 yields in3.
- Register update at each rising clk edge. Priority order: reset > flush > stall > load.
  - rst_n=0: out_data=0, out_valid=0, sel_err=0.
  - flush=1, with or without stall: out_data=0, out_valid=0; sel_err holds.
  - stall=1, flush=0: out_data, out_valid and sel_err all hold.
  - Otherwise (load): out_data=selected values, out_valid=in_valid.
- sel_err set: on a load with in_valid=1 and any lane sel ≥ NUM_IN.
- sel_err clear: only by reset. A load with in_valid=0 never sets it.
- No combinational path from any input to any output.
- When NUM_IN is a power of two, sel_err is constant 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge k appear at out_* after edge k.
- Stall hold is indefinite. On the first non-stalled edge the current inputs are loaded; there is no replay buffer.
- Flush takes effect at the same edge it is sampled, including during a multi-cycle stall.
- Reset asserted mid-stream clears outputs at the next edge. The first load is on the first edge after rst_n returns high.
- Reset values of all outputs are 0.

## Structure
- Package core_pkg holds:
  - the function sel_width(n) returning max(1, clog2(n));
  - the localparams for the default source encodings: SRC_RF=0, SRC_EXMEM=1, SRC_MEMWB=2.
- Sub-module mux_n: a purely combinational, parameterised N:1 selector (WIDTH, NUM_IN) with the out-of-range → last-source rule.
  - Instantiated NUM_LANES times via generate.
  - Flags its own out-of-range select on a 1-bit output; these flags are ORed into the sel_err set logic.
- Top level owns only the pipeline register and the sel_err flag.

## Test plan
- Defaults. Reset, then load lane0 sources {0x11,0x22,0x33} with sel=1 and lane1 sources {0xA,0xB,0xC} with sel=2, in_valid=1 → next cycle out_data lane0=0x22, lane1=0xC, out_valid=1, sel_err=0.
- Out-of-range. sel lane0=3, in_valid=1 → lane0 = source 2 value, sel_err=1. The same with in_valid=0 → sel_err stays 0.
- Stall. Load 0x5, then assert stall for 3 cycles while inputs change to 0x9 → out_data stays 0x5 throughout. Release stall → 0x9 appears one cycle later.
- Flush priority. stall=1 and flush=1 on the same edge with out_valid=1 → out_valid=0, out_data=0. sel_err keeps its prior value.
- Reset mid-stream. sel_err=1 and out_valid=1, rst_n low for one edge → all outputs 0. Loads resume on the next edge.
- Parameter sweep. WIDTH=8, NUM_IN=4, NUM_LANES=3 → every sel 0–3 routes correctly in every lane and sel_err never asserts.
